operand_writeback: RTL

- Consumer end of the move/swap execution path: takes the operand write values (opnd0_w, opnd1_w) and commits each to its destination, either a register-file write port or a memory write channel.
- MOV/MOVSX commit one operand; XCHG commits two, in a fixed order.
- Sits between execute and the register file / memory store interface, accepts one instruction at a time, and pulses done when all writes have retired.

---
 rtl/operand_writeback.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/operand_writeback.sv
// Commits the operand write values of MOV/MOVSX/XCHG to a register-file port or a
// memory write channel, destination 0 first, and pulses done once all writes retire.
module operand_writeback #(
   parameter int unsigned REG_IDX_W = 3,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          opnd0_w,
   input  logic [31:0]          opnd1_w,
   input  logic                 dst0_en,
   input  logic                 dst0_is_mem,
   input  logic [REG_IDX_W-1:0] dst0_reg,
   input  logic [ADDR_W-1:0]    dst0_addr,
   input  logic                 dst1_en,
   input  logic                 dst1_is_mem,
   input  logic [REG_IDX_W-1:0] dst1_reg,
   input  logic [ADDR_W-1:0]    dst1_addr,
   input  logic [1:0]           size,
   output logic                 reg_we,
   output logic [REG_IDX_W-1:0] reg_idx,
   output logic [31:0]          reg_data,
   output logic [3:0]           reg_mask,
   output logic                 mem_valid,
   input  logic                 mem_ready,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [31:0]          mem_data,
   output logic [3:0]           mem_strb,
   output logic                 done
);

   typedef enum logic [1:0] {StIdle, StW0, StW1, StDone} state_e;

   state_e               state_q, state_d;
   logic [31:0]          data0_q, data1_q;
   logic                 en1_q, is_mem0_q, is_mem1_q;
   logic [REG_IDX_W-1:0] reg0_q, reg1_q;
   logic [ADDR_W-1:0]    addr0_q, addr1_q;
   logic [3:0]           mask_q;

   logic                 accept;
   logic                 cur_is_mem;
   logic [REG_IDX_W-1:0] cur_reg;
   logic [ADDR_W-1:0]    cur_addr;
   logic [31:0]          cur_data;

   // Size 3 is reserved and folds onto dword.
   function automatic logic [3:0] size_to_mask(input logic [1:0] s);
      unique case (s)
         2'd0:    size_to_mask = 4'b0001;
         2'd1:    size_to_mask = 4'b0011;
         default: size_to_mask = 4'b1111;
      endcase
   endfunction

   assign accept = (state_q == StIdle) && in_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         data0_q   <= '0;
         data1_q   <= '0;
         en1_q     <= 1'b0;
         is_mem0_q <= 1'b0;
         is_mem1_q <= 1'b0;
         reg0_q    <= '0;
         reg1_q    <= '0;
         addr0_q   <= '0;
         addr1_q   <= '0;
         mask_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            data0_q   <= opnd0_w;
            data1_q   <= opnd1_w;
            en1_q     <= dst1_en;
            is_mem0_q <= dst0_is_mem;
            is_mem1_q <= dst1_is_mem;
            reg0_q    <= dst0_reg;
            reg1_q    <= dst1_reg;
            addr0_q   <= dst0_addr;
            addr1_q   <= dst1_addr;
            mask_q    <= size_to_mask(size);
         end
      end
   end

   always_comb begin
      cur_is_mem = is_mem0_q;
      cur_reg    = reg0_q;
      cur_addr   = addr0_q;
      cur_data   = data0_q;
      if (state_q == StW1) begin
         cur_is_mem = is_mem1_q;
         cur_reg    = reg1_q;
         cur_addr   = addr1_q;
         cur_data   = data1_q;
      end
   end

   // Outputs are zeroed whenever no write is in flight so idle/reset values stay clean.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      reg_we    = 1'b0;
      reg_idx   = '0;
      reg_data  = '0;
      reg_mask  = '0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_data  = '0;
      mem_strb  = '0;
      done      = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (dst0_en)      state_d = StW0;
               else if (dst1_en) state_d = StW1;
               else              state_d = StDone;
            end
         end
         StW0, StW1: begin
            if (cur_is_mem) begin
               mem_valid = 1'b1;
               mem_addr  = cur_addr;
               mem_data  = cur_data;
               mem_strb  = mask_q;
            end else begin
               reg_we   = 1'b1;
               reg_idx  = cur_reg;
               reg_data = cur_data;
               reg_mask = mask_q;
            end
            if (!cur_is_mem || mem_ready) begin
               state_d = (state_q == StW0 && en1_q) ? StW1 : StDone;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule
